// File: rtl/bsg_regfile.sv
// Memory-mapped register file slave on a shared valid/ready bus with a 1-cycle registered response.
// Optional write-lock (register 0 MSB) is compiled in with `define BSG_REGFILE_LOCK_EN.
module bsg_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 3,
    parameter int BASE_ADDR  = 'h10
) (
    input  logic                  G_CLK_TX,
    input  logic                  rst,
    input  logic                  REQ_VALID,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_IN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic                  REQ_READY,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  RSP_ERR
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // Bounds held one bit wider than the bus so BASE_ADDR+NUM_REGS cannot wrap.
    localparam logic [ADDR_WIDTH:0] LO = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] HI = (ADDR_WIDTH+1)'(BASE_ADDR + NUM_REGS);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH:0]   addr_ext;
    logic [IDX_W-1:0]      idx;
    logic                  hit;
    logic                  accept;
    logic                  wr_block;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data;

    assign addr_ext = {1'b0, ADDR_IN};
    assign hit      = (addr_ext >= LO) && (addr_ext < HI);
    assign idx      = IDX_W'(addr_ext - LO);
    assign accept   = REQ_READY;

`ifdef BSG_REGFILE_LOCK_EN
    logic err_q;
    // Register 0 stays writable so the lock can always be cleared.
    assign wr_block = regs_q[0][DATA_WIDTH-1] && (idx != '0);
    assign RSP_ERR  = err_q;

    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst)        err_q <= 1'b0;
        else if (accept) err_q <= REQ_WRITE && wr_block;
    end
`else
    assign wr_block = 1'b0;
    assign RSP_ERR  = 1'b0;
`endif

    assign wr_en = accept && REQ_WRITE && !wr_block;

    // FSM state register
    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RESP;
            RESP:    if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        REQ_READY = (state_q == IDLE) && REQ_VALID && hit;
        RSP_VALID = (state_q == RESP);
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (idx == IDX_W'(k)) rd_data = regs_q[k];
    end

    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                if (wr_en && (idx == IDX_W'(k))) regs_q[k] <= DATA_IN;
        end
    end

    // Response data only changes on accept, so it holds through RESP and after.
    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst)        data_q <= '0;
        else if (accept) data_q <= wr_en ? DATA_IN : rd_data;
    end

    assign DATA_OUT = data_q;
endmodule

// File: tb/tb_bsg_regfile.sv
// Directed bench for bsg_regfile: default instance plus a 16x16-bit instance at 'hF0.
module tb_bsg_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_write = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic        rdy_a, rdy_b, rv_a, rv_b, err_a, err_b;
    logic [7:0]  dout_a;
    logic [15:0] dout_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bsg_regfile u_dut (
        .G_CLK_TX(clk), .rst(rst), .REQ_VALID(vld_a), .REQ_WRITE(req_write),
        .ADDR_IN(addr), .DATA_IN(wdata[7:0]), .REQ_READY(rdy_a), .RSP_VALID(rv_a),
        .RSP_READY(rsp_ready), .DATA_OUT(dout_a), .RSP_ERR(err_a)
    );

    bsg_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REGS(16), .BASE_ADDR('hF0)) u_dut16 (
        .G_CLK_TX(clk), .rst(rst), .REQ_VALID(vld_b), .REQ_WRITE(req_write),
        .ADDR_IN(addr), .DATA_IN(wdata), .REQ_READY(rdy_b), .RSP_VALID(rv_b),
        .RSP_READY(rsp_ready), .DATA_OUT(dout_b), .RSP_ERR(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dout(input bit sel);
        return sel ? dout_b : {8'h00, dout_a};
    endfunction

    // Accepted transaction: checks ready, 1-cycle response, hold after handshake.
    task automatic xact(input string tag, input bit sel, input bit w, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] exp_d, input bit exp_e);
        @(negedge clk);
        req_write = w; addr = a; wdata = d;
        if (sel) vld_b = 1'b1; else vld_a = 1'b1;
        #1 chk({tag, ".rdy"}, sel ? rdy_b : rdy_a, 1);
        @(posedge clk); #1;
        vld_a = 1'b0; vld_b = 1'b0;
        chk({tag, ".rv"}, sel ? rv_b : rv_a, 1);
        chk({tag, ".data"}, dout(sel), exp_d);
        chk({tag, ".err"}, sel ? err_b : err_a, exp_e);
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        chk({tag, ".rv_off"}, sel ? rv_b : rv_a, 0);
        chk({tag, ".hold"}, dout(sel), exp_d);
    endtask

    task automatic miss(input string tag, input bit sel, input logic [7:0] a);
        @(negedge clk);
        req_write = 1'b1; addr = a; wdata = 16'hFFFF;
        if (sel) vld_b = 1'b1; else vld_a = 1'b1;
        #1 chk({tag, ".rdy"}, sel ? rdy_b : rdy_a, 0);
        @(posedge clk); #1;
        chk({tag, ".rv"}, sel ? rv_b : rv_a, 0);
        vld_a = 1'b0; vld_b = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.rv", rv_a, 0);
        chk("rst.data", dout_a, 0);
        chk("rst.err", err_a, 0);
        chk("rst.rdy", rdy_a, 0);
        @(negedge clk) rst = 1'b1;

        // Basic write/read, first accept right after reset release
        xact("wr11", 0, 1, 8'h11, 16'hA5, 16'hA5, 0);
        xact("rd11", 0, 0, 8'h11, 16'h00, 16'hA5, 0);

        // Misses below and above the window leave everything alone
        miss("miss0F", 0, 8'h0F);
        miss("miss13", 0, 8'h13);
        chk("miss.hold", dout_a, 8'hA5);
        xact("rd12", 0, 0, 8'h12, 16'h00, 16'h00, 0);
        xact("rd11b", 0, 0, 8'h11, 16'h00, 16'hA5, 0);

        // Backpressure: response held 5 cycles while a second request waits
        xact("wr10", 0, 1, 8'h10, 16'h5A, 16'h5A, 0);
        @(negedge clk);
        req_write = 1'b0; addr = 8'h10; vld_a = 1'b1;
        @(posedge clk); #1 addr = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall.rv", rv_a, 1);
            chk("stall.data", dout_a, 8'h5A);
            chk("stall.rdy", rdy_a, 0);
        end
        @(negedge clk) rsp_ready = 1'b1;
        #1 chk("hs.rdy", rdy_a, 0);
        @(posedge clk); #1 rsp_ready = 1'b0;
        chk("hs.rv", rv_a, 0);
        chk("hs.rdy2", rdy_a, 1);
        @(posedge clk); #1 vld_a = 1'b0;
        chk("second.rv", rv_a, 1);
        chk("second.data", dout_a, 8'hA5);
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;

        // Reset mid-response wipes the write
        @(negedge clk);
        req_write = 1'b1; addr = 8'h12; wdata = 16'h3C; vld_a = 1'b1;
        @(posedge clk); #1 vld_a = 1'b0;
        chk("pre_rst.rv", rv_a, 1);
        rst = 1'b0;
        #1 chk("async_rst.rv", rv_a, 0);
        chk("async_rst.data", dout_a, 0);
        @(negedge clk) rst = 1'b1;
        xact("rd12_rst", 0, 0, 8'h12, 16'h00, 16'h00, 0);
        xact("rd11_rst", 0, 0, 8'h11, 16'h00, 16'h00, 0);

`ifdef BSG_REGFILE_LOCK_EN
        xact("lk.set", 0, 1, 8'h10, 16'h80, 16'h80, 0);
        xact("lk.wr11", 0, 1, 8'h11, 16'h55, 16'h00, 1);
        xact("lk.rd11", 0, 0, 8'h11, 16'h00, 16'h00, 0);
        xact("lk.clr", 0, 1, 8'h10, 16'h00, 16'h00, 0);
        xact("lk.wr11b", 0, 1, 8'h11, 16'h55, 16'h55, 0);
`else
        xact("nolk.set", 0, 1, 8'h10, 16'h80, 16'h80, 0);
        xact("nolk.wr11", 0, 1, 8'h11, 16'h55, 16'h55, 0);
        xact("nolk.rd11", 0, 0, 8'h11, 16'h00, 16'h55, 0);
`endif

        // Wide instance at the top of the address space
        xact("w16.wrFF", 1, 1, 8'hFF, 16'hBEEF, 16'hBEEF, 0);
        xact("w16.rdFF", 1, 0, 8'hFF, 16'h0000, 16'hBEEF, 0);
        xact("w16.rdF0", 1, 0, 8'hF0, 16'h0000, 16'h0000, 0);
        miss("w16.miss00", 1, 8'h00);
        miss("w16.missEF", 1, 8'hEF);
        chk("w16.hold", dout_b, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bsg_regfile.md
BSG_REGFILE -- requirements
Module: bsg_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the register and data-bus width (legal 8..32).
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the address-bus width.
REQ-003 Parameter NUM_REGS, default 3, SHALL set the register count (legal 1..16).
REQ-004 Parameter BASE_ADDR, default 'h10, SHALL set the address of register 0; register k SHALL sit at BASE_ADDR+k.
REQ-005 G_CLK_TX  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 REQ_VALID  input  1  SHALL signal that a request is present.
REQ-008 REQ_WRITE  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-009 ADDR_IN  input  ADDR_WIDTH  SHALL carry the request address on the shared bus.
REQ-010 DATA_IN  input  DATA_WIDTH  SHALL carry the write data.
REQ-011 REQ_READY  output  1  SHALL be high when this block accepts the current request.
REQ-012 RSP_VALID  output  1  SHALL be high when a response is presented.
REQ-013 RSP_READY  input  1  SHALL signal that the requester consumes the response.
REQ-014 DATA_OUT  output  DATA_WIDTH  SHALL carry the response data.
REQ-015 RSP_ERR  output  1  SHALL flag a rejected access; it is valid only with RSP_VALID.

Function
REQ-016 A hit SHALL mean BASE_ADDR <= ADDR_IN < BASE_ADDR+NUM_REGS, compared unsigned at ADDR_WIDTH+1 bits so the upper bound cannot wrap.
REQ-017 The FSM SHALL have exactly two states: IDLE and RESP.
REQ-018 REQ_READY SHALL be combinational, equal to (state==IDLE) && REQ_VALID && hit.
REQ-019 A request that misses SHALL leave all registers, outputs and the FSM state unchanged, because other slaves share the bus.
REQ-020 On a write accept edge, register[ADDR_IN-BASE_ADDR] SHALL load DATA_IN; the response DATA_OUT SHALL be the value written.
REQ-021 On a read accept edge, DATA_OUT SHALL load register[ADDR_IN-BASE_ADDR].
REQ-022 An accept in IDLE SHALL move the FSM to RESP; RSP_VALID SHALL be high from the next cycle, giving 1-cycle latency.
REQ-023 In RESP, RSP_VALID, DATA_OUT and RSP_ERR SHALL hold stable until RSP_READY is sampled high.
REQ-024 RSP_VALID && RSP_READY SHALL return the FSM to IDLE; no request SHALL be accepted in that same cycle.
REQ-025 Requests presented while in RESP SHALL be ignored, with REQ_READY low.
REQ-026 After RSP_VALID falls, DATA_OUT SHALL keep its last response value.

Reset
REQ-027 While rst is low, the FSM SHALL be IDLE and every register, DATA_OUT, RSP_VALID and RSP_ERR SHALL be 0.
REQ-028 Reset asserted while in RESP SHALL drop the response immediately; no write accepted before reset SHALL survive it.
REQ-029 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro BSG_REGFILE_LOCK_EN SHALL compile in write-lock: register 0 bit DATA_WIDTH-1 is the LOCK bit.
REQ-031 With the macro defined and LOCK=1:
- writes to registers 1..NUM_REGS-1 SHALL be discarded;
- the response SHALL carry RSP_ERR=1 and DATA_OUT = current register content;
- register 0 SHALL always stay writable.
REQ-032 Without the macro, no lock logic SHALL exist, RSP_ERR SHALL be tied to 0, and all registers SHALL always be writable.

Verification
REQ-033 Reset, then write 'hA5 to 'h11 and read 'h11 -> both responses arrive 1 cycle after accept; read DATA_OUT='hA5; RSP_ERR=0.
REQ-034 Request to 'h0F and to 'h13 with NUM_REGS=3 -> REQ_READY=0, RSP_VALID stays 0, registers unchanged.
REQ-035 Read 'h10 with RSP_READY held low 5 cycles while a second request waits -> RSP_VALID and DATA_OUT stable 5 cycles; second request accepted only in the cycle after the handshake.
REQ-036 rst pulsed low while in RESP after writing 'h3C to 'h12 -> RSP_VALID=0 at once; later read of 'h12 returns 'h00.
REQ-037 With BSG_REGFILE_LOCK_EN: write 'h80 to 'h10, then write 'h55 to 'h11 -> RSP_ERR=1, read 'h11 returns 'h00; write 'h00 to 'h10 clears the lock.
REQ-038 With DATA_WIDTH=16, NUM_REGS=16, BASE_ADDR='hF0 -> write/read 'hBEEF at 'hFF succeeds, and 'h00 misses with no wrap.
